// File: rtl/alu_wb_seq.sv
// alu_wb_seq: execute/writeback sequencer between the accumulator register
// file read ports and its write port. Runs one ALU op per start request,
// either in a single cycle (ADD/SUB/AND/XOR/MOV, zero-count shifts) or
// iteratively (shifts one bit per cycle, shift-add multiply), then issues
// exactly one write strobe in the WB cycle.
//
// Optional feature macro: ALU_MUL_EN
//   defined   -> op 6 is a W-cycle unsigned shift-add multiply
//   undefined -> op 6 is a one-cycle NOP: done pulses, no strobe, and
//                writeValue/carry/zero keep their previous values
module alu_wb_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         dest_acc,
  input  logic [D-1:0] reg_index_in,
  input  logic [W-1:0] Acc_in,
  input  logic [W-1:0] Reg_in,
  output logic         busy,
  output logic         done,
  output logic         AccWrite,
  output logic         RegWrite,
  output logic [D-1:0] reg_index,
  output logic [W-1:0] writeValue,
  output logic         carry,
  output logic         zero
);

  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic            dest_q;
  logic [D-1:0]    idx_q;
  logic [W-1:0]    sh_q;
  logic [CW-1:0]   cnt_q;

`ifdef ALU_MUL_EN
  logic [W-1:0]    mcand_q;
  logic [2*W-1:0]  prod_q;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  prod_next;
`endif

  logic [W:0]      fast_sum;
  logic [W-1:0]    fast_res;
  logic            fast_cy;
  logic            long_shift;
  logic [W-1:0]    sh_next;
  logic [W-1:0]    exec_res;
  logic            exec_cy;

  // Single-cycle result straight from the read ports at the accepting edge
  always_comb begin
    fast_sum = '0;
    fast_res = Acc_in;
    fast_cy  = 1'b0;
    case (op)
      OP_ADD: begin
        fast_sum = {1'b0, Acc_in} + {1'b0, Reg_in};
        fast_res = fast_sum[W-1:0];
        fast_cy  = fast_sum[W];
      end
      OP_SUB: begin
        // Bit W of the widened difference is the borrow (A < B unsigned)
        fast_sum = {1'b0, Acc_in} - {1'b0, Reg_in};
        fast_res = fast_sum[W-1:0];
        fast_cy  = fast_sum[W];
      end
      OP_AND:  fast_res = Acc_in & Reg_in;
      OP_XOR:  fast_res = Acc_in ^ Reg_in;
      OP_MOV:  fast_res = Reg_in;
      default: fast_res = Acc_in;
    endcase
  end

  // Shifts with a nonzero count need the iterative path
  always_comb begin
    long_shift = ((op == OP_SHL) || (op == OP_SHR)) && (Reg_in[2:0] != 3'd0);
  end

  // One iteration of the multi-cycle datapath from the latched operands
  always_comb begin
    if (op_q == OP_SHL) begin
      sh_next = {sh_q[W-2:0], 1'b0};
      exec_cy = sh_q[W-1];
    end else begin
      sh_next = {1'b0, sh_q[W-1:1]};
      exec_cy = sh_q[0];
    end
    exec_res = sh_next;
`ifdef ALU_MUL_EN
    // Add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole product right by one
    mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {mul_sum, prod_q[W-1:1]};
    if (op_q == OP_MUL) begin
      exec_res = prod_next[W-1:0];
      exec_cy  = |prod_next[2*W-1:W];
    end
`endif
  end

  // Sequencer: IDLE -> (EXEC) -> WB -> IDLE with registered strobes and flags
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      AccWrite   <= 1'b0;
      RegWrite   <= 1'b0;
      reg_index  <= '0;
      writeValue <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      op_q       <= '0;
      dest_q     <= 1'b0;
      idx_q      <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
`ifdef ALU_MUL_EN
      mcand_q    <= '0;
      prod_q     <= '0;
`endif
    end else begin
      done     <= 1'b0;
      AccWrite <= 1'b0;
      RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            dest_q <= dest_acc;
            idx_q  <= reg_index_in;
            sh_q   <= Acc_in;
            busy   <= 1'b1;
            if (op == OP_MUL) begin
`ifdef ALU_MUL_EN
              mcand_q <= Acc_in;
              prod_q  <= {W'(0), Reg_in};
              cnt_q   <= CW'(W);
              state   <= EXEC;
`else
              done  <= 1'b1;
              state <= WB;
`endif
            end else if (long_shift) begin
              cnt_q <= CW'(Reg_in[2:0]);
              state <= EXEC;
            end else begin
              writeValue <= fast_res;
              carry      <= fast_cy;
              zero       <= (fast_res == '0);
              AccWrite   <= dest_acc;
              RegWrite   <= ~dest_acc;
              reg_index  <= reg_index_in;
              done       <= 1'b1;
              state      <= WB;
            end
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - CW'(1);
          sh_q  <= sh_next;
`ifdef ALU_MUL_EN
          prod_q <= prod_next;
`endif
          // Last iteration writes back directly so WB lands on t+1+count
          if (cnt_q == CW'(1)) begin
            writeValue <= exec_res;
            carry      <= exec_cy;
            zero       <= (exec_res == '0);
            AccWrite   <= dest_q;
            RegWrite   <= ~dest_q;
            reg_index  <= idx_q;
            done       <= 1'b1;
            state      <= WB;
          end
        end
        WB: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
